cp0_int_ctrl: RTL
=================

# cp0_int_ctrl

Parametrised CP0 timer and interrupt controller for the PipelineMIPS MEM stage. It owns Count/Compare with a configurable prescaler and a sticky timer-interrupt flag. It synchronises a configurable number of hardware interrupt lines and holds the software-interrupt bits. It produces the Cause.IP vector and a masked interrupt request that the exception unit turns into an interrupt exception.

## Interface
- HW_INT_NUM, 6: number of external hardware interrupt lines (1–6).
- SW_INT_NUM, 2: number of software interrupt bits (fixed meaning IP[SW_INT_NUM-1:0]).
- COUNT_DIV, 2: clk cycles per Count increment (≥1; 1 = every cycle).
- SYNC_STAGES, 2: flip-flop stages on each ext_int line (≥1).
- TIMER_LINE, 7: IP bit index ORed with the timer flag (SW_INT_NUM ≤ TIMER_LINE < SW_INT_NUM+HW_INT_NUM).
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- ext_int  in  HW_INT_NUM  asynchronous level interrupt lines.
- wen  in  1  mtc0 write enable (MEM stage, already qualified by no exception).
- addr  in  5  CP0 register number.
- wdata  in  32  mtc0 data.
- status_ie, status_exl  in  1 each  Status.IE, Status.EXL.
- status_im  in  SW_INT_NUM+HW_INT_NUM  Status.IM.
- count  out  32  Count register.
- compare  out  32  Compare register.
- cause_ip  out  SW_INT_NUM+HW_INT_NUM  Cause.IP as read by mfc0.
- timer_int  out  1  sticky timer flag (Cause.TI).
- int_req  out  1  registered interrupt request to the exception unit.

## Operation
- Register numbers: COUNT=9, COMPARE=11, CAUSE=13. Writes to other addresses are ignored.
- Prescaler: pre_cnt counts 0..COUNT_DIV-1 and wraps. A tick occurs when pre_cnt==COUNT_DIV-1, and Count increments by 1 (mod 2^32) on a tick.
- Count write: count←wdata and pre_cnt←0. No tick in that cycle.
- Compare write: compare←wdata and timer_int←0, taking precedence over a same-cycle set.
- Timer set: on a tick where count+1==compare, timer_int←1. It stays set until a Compare write or rst. Compare=0 is valid, so a match on wrap to 0 sets the flag.
- A Count write of a value equal to compare does not set the flag; only an increment does.
- HW lines: each line passes through a SYNC_STAGES-deep synchroniser. IP[SW_INT_NUM+i] equals synchronised ext_int[i] (level, not sticky).
- cause_ip[TIMER_LINE] is additionally ORed with timer_int.
- SW bits: a Cause write sets IP[SW_INT_NUM-1:0]←wdata[8 +: SW_INT_NUM]. The bits hold until the next Cause write. A Cause write never affects the HW or timer bits.
- int_req is registered: int_req ← status_ie & ~status_exl & |(cause_ip & status_im), evaluated on current register values.

## Timing
- Reset values: count=0, compare=0, pre_cnt=0, timer_int=0, synchronisers=0, SW IP=0, cause_ip=0, int_req=0.
- rst mid-operation clears all state in the same edge. It overrides wen.
- Count, Compare and SW IP writes are visible on outputs the cycle after wen.
- ext_int to cause_ip latency: SYNC_STAGES cycles. ext_int to int_req latency: SYNC_STAGES+1 cycles.
- Timer: the match tick edge sets timer_int, and int_req follows one cycle later.
- Simultaneous Count write and tick: the write wins. Simultaneous Compare write and match: the flag is cleared and compare takes wdata.
- Count wraps 0xFFFF_FFFF→0 without a flag, unless compare==0.
- COUNT_DIV=1: pre_cnt is absent and every non-write cycle is a tick.

## Structure
- Shared package/defines.vh: CP0_COUNT, CP0_COMPARE, CP0_CAUSE, IP field offset (8), TI bit (30).
- One sub-module: cp0_sync_bit (SYNC_STAGES-deep single-bit synchroniser, reset to 0), instantiated HW_INT_NUM times via generate.
- Prescaler, Count/Compare, IP assembly and int_req in the top.

## Test plan
- Reset, then idle 10 cycles with COUNT_DIV=2 → count=5, timer_int=0, int_req=0.
- Write compare=3, IE=1, EXL=0, IM[7]=1 → timer_int rises on the tick where count goes 2→3, and int_req rises 1 cycle later. Then write compare=100 → both clear.
- Write count=0xFFFF_FFFF with compare=0 → wrap to 0 sets timer_int. Repeat with compare=5 → no set at wrap.
- Pulse ext_int[2] high for 4 cycles with IM[4]=1 → cause_ip[4] high for 4 cycles after a SYNC_STAGES delay. int_req is the same, shifted by 1 cycle. With EXL=1 → int_req stays 0.
- Cause write wdata[9:8]=2'b10 → cause_ip[1:0]=2'b10 next cycle and HW bits are unchanged. With IM[1]=1 and IE=1 → int_req=1.
- Same-cycle Compare write and a matching tick → timer_int=0 and compare=wdata. Assert rst during a running count → all outputs 0 next cycle.

Source files
------------

// File: rtl/cp0_int_ctrl_pkg.sv
// Shared CP0 register numbers and Cause field positions for the
// PipelineMIPS timer / interrupt controller.
package cp0_int_ctrl_pkg;

  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;

  // Cause.IP starts at bit 8; Cause.TI is bit 30.
  localparam int IP_OFFSET = 8;
  localparam int TI_BIT    = 30;

endpackage

// File: rtl/cp0_int_ctrl_if.sv
// mtc0 write port from the MEM stage into the CP0 interrupt controller.
interface cp0_int_ctrl_if;

  // wen is a valid-only strobe: addr/wdata are meaningful only while wen=1,
  // and the slave always accepts the write on that same clock edge (no ready).
  logic        wen;
  logic [4:0]  addr;
  logic [31:0] wdata;

  modport master (
    output wen,
    output addr,
    output wdata
  );

  modport slave (
    input wen,
    input addr,
    input wdata
  );

endinterface

// File: rtl/cp0_int_ctrl_sync.sv
// Single-bit multi-stage synchroniser for one asynchronous interrupt line.
module cp0_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sr;

    // Shift form works for STAGES=1 as well as deeper chains.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= '0;
        end else begin
            sr <= (sr << 1) | STAGES'(d);
        end
    end

    assign q = sr[STAGES-1];

endmodule

// File: rtl/cp0_int_ctrl.sv
// CP0 Count/Compare timer with prescaler, HW/SW interrupt pending bits and
// the registered interrupt request handed to the exception unit.
module cp0_int_ctrl
    import cp0_int_ctrl_pkg::*;
#(
    parameter int HW_INT_NUM  = 6,
    parameter int SW_INT_NUM  = 2,
    parameter int COUNT_DIV   = 2,
    parameter int SYNC_STAGES = 2,
    parameter int TIMER_LINE  = 7
) (
    input  logic                             clk,
    input  logic                             rst,
    cp0_int_ctrl_if.slave                    wr,
    input  logic [HW_INT_NUM-1:0]            ext_int,
    input  logic                             status_ie,
    input  logic                             status_exl,
    input  logic [SW_INT_NUM+HW_INT_NUM-1:0] status_im,
    output logic [31:0]                      count,
    output logic [31:0]                      compare,
    output logic [SW_INT_NUM+HW_INT_NUM-1:0] cause_ip,
    output logic                             timer_int,
    output logic                             int_req
);

    localparam int IP_W = SW_INT_NUM + HW_INT_NUM;

    logic                  count_wr;
    logic                  compare_wr;
    logic                  cause_wr;
    logic                  tick_raw;
    logic                  tick;
    logic                  timer_hit;
    logic [HW_INT_NUM-1:0] hw_sync;
    logic [SW_INT_NUM-1:0] sw_ip;

    assign count_wr   = wr.wen && (wr.addr == CP0_COUNT);
    assign compare_wr = wr.wen && (wr.addr == CP0_COMPARE);
    assign cause_wr   = wr.wen && (wr.addr == CP0_CAUSE);

    // Prescaler: a Count write restarts the divide period.
    generate
        if (COUNT_DIV > 1) begin : g_pre
            localparam int PW = $clog2(COUNT_DIV);
            logic [PW-1:0] pre_cnt;

            always_ff @(posedge clk) begin
                if (rst || count_wr) begin
                    pre_cnt <= '0;
                end else if (pre_cnt == PW'(COUNT_DIV - 1)) begin
                    pre_cnt <= '0;
                end else begin
                    pre_cnt <= pre_cnt + 1'b1;
                end
            end

            assign tick_raw = (pre_cnt == PW'(COUNT_DIV - 1));
        end else begin : g_nopre
            assign tick_raw = 1'b1;
        end
    endgenerate

    assign tick      = tick_raw && !count_wr;
    assign timer_hit = tick && ((count + 32'd1) == compare);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (count_wr) begin
            count <= wr.wdata;
        end else if (tick) begin
            count <= count + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            compare <= '0;
        end else if (compare_wr) begin
            compare <= wr.wdata;
        end
    end

    // Compare write clears the flag even if this edge is also a match tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_int <= 1'b0;
        end else if (compare_wr) begin
            timer_int <= 1'b0;
        end else if (timer_hit) begin
            timer_int <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_ip <= '0;
        end else if (cause_wr) begin
            sw_ip <= wr.wdata[IP_OFFSET +: SW_INT_NUM];
        end
    end

    generate
        for (genvar i = 0; i < HW_INT_NUM; i++) begin : g_sync
            cp0_sync_bit #(
                .STAGES (SYNC_STAGES)
            ) u_sync (
                .clk (clk),
                .rst (rst),
                .d   (ext_int[i]),
                .q   (hw_sync[i])
            );
        end
    endgenerate

    always_comb begin
        cause_ip             = {hw_sync, sw_ip};
        cause_ip[TIMER_LINE] = cause_ip[TIMER_LINE] | timer_int;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            int_req <= 1'b0;
        end else begin
            int_req <= status_ie && !status_exl && (|(cause_ip & status_im));
        end
    end

    logic unused_ip_w;
    assign unused_ip_w = (IP_W == 0);

endmodule
